cla_seq_multiplier: RTL and testbench

Iterative shift-and-add unsigned multiplier for the RISC execute stage. It produces a 2*WIDTH-bit product over WIDTH cycles and uses no adder of its own. Each cycle it drives one operand pair into the shared 32-bit carry-lookahead adder (add_a/add_b) and consumes that adder's sum and carry-out on the same cycle. It is therefore directly upstream and downstream of the adder. The core-side interface is a start/busy/done handshake.

---
 rtl/cla_seq_multiplier_pkg.sv | 13 +
 rtl/cla_mul_datapath.sv | 51 +++++
 rtl/cla_seq_multiplier.sv | 88 ++++++++
 tb/tb_cla_seq_multiplier.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cla_seq_multiplier_pkg.sv
// rtl/cla_seq_multiplier_pkg.sv - shared state encoding and default width for the sequential multiplier
package cla_seq_multiplier_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/cla_mul_datapath.sv
// rtl/cla_mul_datapath.sv - accumulator/multiplicand registers and adder operand mux
module cla_mul_datapath
  import cla_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_cout,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic [2*WIDTH-1:0]   next_product
);

  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] mcand_r;

  // Operands are forced to zero outside RUN so the shared adder stays quiet.
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (step) begin
      add_a = acc_hi;
      add_b = acc_lo[0] ? mcand_r : '0;
    end
  end

  // Carry-out lands in the top bit of acc_hi after the right shift.
  assign next_product = {add_cout, add_sum, acc_lo[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi  <= '0;
      acc_lo  <= '0;
      mcand_r <= '0;
    end else if (load) begin
      mcand_r <= mcand;
      acc_hi  <= '0;
      acc_lo  <= mplier;
    end else if (step) begin
      {acc_hi, acc_lo} <= next_product;
    end
  end

endmodule

// File: rtl/cla_seq_multiplier.sv
// rtl/cla_seq_multiplier.sv - iterative shift-and-add unsigned multiplier driving an external CLA
module cla_seq_multiplier
  import cla_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_cout
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  mul_state_t         state;
  logic [CNT_W-1:0]   count;
  logic               load;
  logic               step;
  logic [2*WIDTH-1:0] next_product;

  // A new request is only honoured when no operation is in flight.
  assign load = start && ((state == IDLE) || (state == DONE));
  assign step = (state == RUN);

  cla_mul_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .step         (step),
    .mcand        (mcand),
    .mplier       (mplier),
    .add_sum      (add_sum),
    .add_cout     (add_cout),
    .add_a        (add_a),
    .add_b        (add_b),
    .next_product (next_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            count <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          count <= count + CNT_W'(1);
          if (count == LAST_ITER) begin
            state   <= DONE;
            product <= next_product;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_multiplier.sv
// tb/tb_cla_seq_multiplier.sv - self-checking bench with behavioural model and adder stand-in
module tb_cla_seq_multiplier;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   mcand = '0;
  logic [W-1:0]   mplier = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W-1:0]   add_sum;
  logic           add_cout;

  int checks = 0;
  int passed = 0;

  cla_seq_multiplier #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mcand    (mcand),
    .mplier   (mplier),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model: a request taken while idle yields a*b exactly W cycles later.
  int             m_left = 0;
  logic           m_done = 1'b0;
  logic [2*W-1:0] m_product = '0;
  logic [2*W-1:0] m_pending = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_product = '0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_product = m_pending;
        m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_pending = 64'(mcand) * 64'(mplier);
        m_left = W;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 64'(busy), 64'(m_left > 0));
      chk("done", 64'(done), 64'(m_done));
      chk("product", product, m_product);
      if (m_left == 0) begin
        chk("add_a_idle", 64'(add_a), 64'd0);
        chk("add_b_idle", 64'(add_b), 64'd0);
      end
    end
  end

  task automatic pulse(input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    mcand = a; mplier = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output logic [2*W-1:0] p, output int cycles, output int busy_cycles,
                           output logic b_nz);
    p = '0; cycles = 0; busy_cycles = 0; b_nz = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cycles++;
      if (busy) busy_cycles++;
      if (add_b != '0) b_nz = 1'b1;
      if (done) begin
        p = product;
        return;
      end
    end
    chk("done_timeout", 64'd1, 64'd0);
  endtask

  logic [2*W-1:0] p;
  int             cyc;
  int             bcyc;
  logic           bnz;

  initial begin
    #12;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_product", product, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    pulse(32'd3, 32'd5);
    wait_done(p, cyc, bcyc, bnz);
    chk("3x5", p, 64'h0000_0000_0000_000F);
    chk("3x5_latency", 64'(cyc), 64'd33);
    chk("3x5_busy_cycles", 64'(bcyc), 64'd32);

    pulse(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(p, cyc, bcyc, bnz);
    chk("max_x_max", p, 64'hFFFF_FFFE_0000_0001);

    pulse(32'h1234_5678, 32'd0);
    wait_done(p, cyc, bcyc, bnz);
    chk("x_zero", p, 64'd0);
    chk("x_zero_busy_cycles", 64'(bcyc), 64'd32);
    chk("x_zero_add_b", 64'(bnz), 64'd0);

    pulse(32'd7, 32'd9);
    repeat (9) @(posedge clk);
    #1; mcand = 32'd2; mplier = 32'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(p, cyc, bcyc, bnz);
    chk("7x9_ignore_start", p, 64'd63);
    pulse(32'd2, 32'd2);
    wait_done(p, cyc, bcyc, bnz);
    chk("2x2", p, 64'd4);

    pulse(32'd5, 32'd5);
    repeat (14) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    chk("midrun_reset_busy", 64'(busy), 64'd0);
    chk("midrun_reset_done", 64'(done), 64'd0);
    chk("midrun_reset_product", product, 64'd0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    bnz = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) bnz = 1'b1;
    end
    chk("no_done_after_reset", 64'(bnz), 64'd0);
    pulse(32'd6, 32'd7);
    wait_done(p, cyc, bcyc, bnz);
    chk("6x7", p, 64'd42);

    pulse(32'd4, 32'd4);
    repeat (20) @(posedge clk);
    #1; mcand = 32'd10; mplier = 32'd10; start = 1'b1;
    wait_done(p, cyc, bcyc, bnz);
    chk("4x4_b2b", p, 64'd16);
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("b2b_rerun_busy", 64'(busy), 64'd1);
    wait_done(p, cyc, bcyc, bnz);
    chk("10x10_b2b", p, 64'd100);
    chk("10x10_latency", 64'(cyc), 64'd32);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
